// File: rtl/branch_pc_unit_if.sv
// Purpose : control/fetch-side bundle for the next-PC unit.
// Latency : none (wires only).
// Backpressure: none; the PC advances every clock.
// master: control unit / fetch (drives npc_sel, ext, imm16; observes the PCs)
// slave : branch_pc_unit (consumes the selects, drives pc/pc_plus4/branch_target)
interface branch_pc_unit_if;
    logic        npc_sel;
    logic        ext;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    modport master (
        output npc_sel, ext, imm16,
        input  pc, pc_plus4, branch_target
    );

    modport slave (
        input  npc_sel, ext, imm16,
        output pc, pc_plus4, branch_target
    );
endinterface

// File: rtl/branch_pc_unit.sv
// Purpose : program counter with sequential (PC+4) or PC-relative branch next-PC.
// Latency : one cycle from npc_sel/imm16/ext to pc; pc_plus4/branch_target are combinational.
// Backpressure: none; no stall input, the PC advances on every rising clk edge.
//
// Ports: clk, reset (async, active-high; pc = RESET_PC while high),
//        bus (branch_pc_unit_if.slave): npc_sel, ext, imm16 in; pc, pc_plus4, branch_target out.
// Build option: define BRANCH_WORD_OFFSET_EN to treat imm16 as a word offset (shifted left by 2);
//               otherwise imm16 is a byte offset.

module and_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module mux_32 (
    input  logic [31:0] sel,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    output logic [31:0] out
);
    assign out = (sel == 32'd0) ? src0 : src1;
endmodule

module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h00400020
) (
    input  logic           clk,
    input  logic           reset,
    branch_pc_unit_if.slave bus
);
    logic        sign;
    logic [31:0] imm_ext;
    logic [31:0] offset;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    // Sign bit only survives when sign-extension is requested.
    and_gate u_sign_gate (
        .a (bus.ext),
        .b (bus.imm16[15]),
        .y (sign)
    );

    assign imm_ext = {{16{sign}}, bus.imm16};

`ifdef BRANCH_WORD_OFFSET_EN
    assign offset = {imm_ext[29:0], 2'b00};
`else
    assign offset = imm_ext;
`endif

    // Modulo-2^32 arithmetic; carry-out intentionally dropped.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + offset;

    mux_32 u_npc_mux (
        .sel  ({31'b0, bus.npc_sel}),
        .src0 (pc_plus4),
        .src1 (branch_target),
        .out  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.branch_target = branch_target;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Purpose : self-checking bench for branch_pc_unit (two instances: default and wrap-around reset PC).
// Latency : expected PCs are queued when inputs are driven and popped one edge later.
// Backpressure: none; every clock edge produces a new PC.
`timescale 1ns/1ps

module tb_branch_pc_unit;
    logic clk;
    logic reset0;
    logic reset1;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc[2];

    localparam logic [31:0] RST0 = 32'h00400020;
    localparam logic [31:0] RST1 = 32'hFFFFFFFC;

    branch_pc_unit_if bus0 ();
    branch_pc_unit_if bus1 ();

    branch_pc_unit #(.RESET_PC(RST0)) dut0 (
        .clk   (clk),
        .reset (reset0),
        .bus   (bus0.slave)
    );

    branch_pc_unit #(.RESET_PC(RST1)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic s,
                                               input logic e, input logic [15:0] i);
        logic [31:0] ie;
        logic [31:0] off;
        ie = {{16{e & i[15]}}, i};
`ifdef BRANCH_WORD_OFFSET_EN
        off = ie * 32'd4;
`else
        off = ie;
`endif
        return s ? (p + 32'd4 + off) : (p + 32'd4);
    endfunction

    function automatic logic [31:0] dut_pc(input int d);
        return (d == 0) ? bus0.pc : bus1.pc;
    endfunction

    // Called just after a rising edge: drive inputs, check combinational outputs,
    // queue the expected PC, then compare it after the next edge.
    task automatic step(input int d, input logic s, input logic e, input logic [15:0] i,
                        input string tag);
        logic [31:0] got_p4;
        logic [31:0] got_bt;
        logic [31:0] got;
        if (d == 0) begin
            bus0.npc_sel = s; bus0.ext = e; bus0.imm16 = i;
        end else begin
            bus1.npc_sel = s; bus1.ext = e; bus1.imm16 = i;
        end
        #1;
        got_p4 = (d == 0) ? bus0.pc_plus4 : bus1.pc_plus4;
        got_bt = (d == 0) ? bus0.branch_target : bus1.branch_target;
        check({tag, "_p4"}, got_p4, model_pc[d] + 32'd4);
        check({tag, "_bt"}, got_bt, model_next(model_pc[d], 1'b1, e, i));
        exp_q.push_back(model_next(model_pc[d], s, e, i));
        @(posedge clk);
        #1;
        got = dut_pc(d);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            model_pc[d] = exp_q.pop_front();
            check({tag, "_pc"}, got, model_pc[d]);
        end
    endtask

    // Called just after a rising edge: reset across one edge, release after it.
    task automatic do_reset(input int d, input string tag);
        if (d == 0) reset0 = 1'b1; else reset1 = 1'b1;
        #1;
        check({tag, "_async"}, dut_pc(d), (d == 0) ? RST0 : RST1);
        @(posedge clk);
        #1;
        check({tag, "_held"}, dut_pc(d), (d == 0) ? RST0 : RST1);
        if (d == 0) reset0 = 1'b0; else reset1 = 1'b0;
        model_pc[d] = (d == 0) ? RST0 : RST1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset0 = 1'b1;
        reset1 = 1'b1;
        bus0.npc_sel = 1'b0; bus0.ext = 1'b0; bus0.imm16 = 16'h0000;
        bus1.npc_sel = 1'b0; bus1.ext = 1'b0; bus1.imm16 = 16'h0000;
        model_pc[0] = RST0;
        model_pc[1] = RST1;

        #2;
        check("rst_pc", bus0.pc, 32'h00400020);
        check("rst_p4", bus0.pc_plus4, 32'h00400024);
        @(posedge clk);
        #1;
        reset0 = 1'b0;

        // Advance to 0x00400028, then assert reset mid-cycle.
        step(0, 1'b0, 1'b0, 16'h0000, "pre1");
        step(0, 1'b0, 1'b0, 16'h0000, "pre2");
        check("pre_pc", bus0.pc, 32'h00400028);
        #2;
        reset0 = 1'b1;
        #1;
        check("mid_rst", bus0.pc, 32'h00400020);
        @(posedge clk);
        #1;
        check("rst_hold", bus0.pc, 32'h00400020);
        reset0 = 1'b0;
        model_pc[0] = RST0;

        // Sequential run.
        step(0, 1'b0, 1'b1, 16'h1234, "seq1");
        check("seq1_lit", bus0.pc, 32'h00400024);
        step(0, 1'b0, 1'b1, 16'h1234, "seq2");
        check("seq2_lit", bus0.pc, 32'h00400028);
        step(0, 1'b0, 1'b1, 16'h1234, "seq3");
        check("seq3_lit", bus0.pc, 32'h0040002C);

        // Forward branch.
        do_reset(0, "r_fwd");
        step(0, 1'b1, 1'b1, 16'h0010, "fwd");
`ifdef BRANCH_WORD_OFFSET_EN
        check("fwd_lit", bus0.pc, 32'h00400064);
`else
        check("fwd_lit", bus0.pc, 32'h00400034);
`endif

        // Backward branch, sign-extended.
        do_reset(0, "r_bwd");
        step(0, 1'b1, 1'b1, 16'hFFF8, "bwd");
`ifdef BRANCH_WORD_OFFSET_EN
        check("bwd_lit", bus0.pc, 32'h00400004);
`else
        check("bwd_lit", bus0.pc, 32'h0040001C);
`endif

        // Same immediate, zero-extended.
        do_reset(0, "r_zx");
        step(0, 1'b1, 1'b0, 16'hFFF8, "zx");
`ifdef BRANCH_WORD_OFFSET_EN
        check("zx_lit", bus0.pc, 32'h00440004);
`else
        check("zx_lit", bus0.pc, 32'h0041001C);
`endif

        // Select toggling from reset.
        do_reset(0, "r_tog");
        for (int k = 0; k < 4; k++) begin
            step(0, k[0], 1'b1, 16'h0008, $sformatf("tog%0d", k));
        end
`ifdef BRANCH_WORD_OFFSET_EN
        check("tog_lit", bus0.pc, 32'h00400020 + 32'd80);
`else
        check("tog_lit", bus0.pc, 32'h00400020 + 32'd32);
`endif

        // A few random steps against the model.
        for (int k = 0; k < 20; k++) begin
            step(0, 1'(($urandom) & 1), 1'(($urandom) & 1), 16'($urandom), $sformatf("rnd%0d", k));
        end

        // Wrap-around on the second instance.
        reset0 = 1'b1;
        check("w_rst", bus1.pc, 32'hFFFFFFFC);
        reset1 = 1'b0;
        model_pc[1] = RST1;
        step(1, 1'b0, 1'b1, 16'h0004, "wrap_seq");
        check("wrap_seq_lit", bus1.pc, 32'h00000000);
        do_reset(1, "r_wrap");
        step(1, 1'b1, 1'b1, 16'h0004, "wrap_br");
`ifdef BRANCH_WORD_OFFSET_EN
        check("wrap_br_lit", bus1.pc, 32'h00000010);
`else
        check("wrap_br_lit", bus1.pc, 32'h00000004);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
